activity_monitor: RTL and testbench

- Parametrised successor to the fixed six-input activity detector.
- Accepts NUM_CH asynchronous button/sensor levels. Each channel is synchronised, debounced, and turned into a per-channel single-cycle rising-edge event.
- Drives a combined activity pulse (events plus one boot pulse), plus channel-mask, priority-index and idle-timeout outputs for the game controller.

---
 rtl/activity_monitor_pkg.sv | 22 ++
 rtl/activity_monitor_channel_edge_filter.sv | 64 ++++++
 rtl/activity_monitor.sv | 109 ++++++++++
 tb/tb_activity_monitor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/activity_monitor_pkg.sv
// Shared helpers for activity_monitor: ceiling-log2 and a width helper
// that never returns less than one bit.
package activity_monitor_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 32'sd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    function automatic int min1_clog2(input int value);
        return (clog2(value) < 32'sd1) ? 32'sd1 : clog2(value);
    endfunction

endpackage

// File: rtl/activity_monitor_channel_edge_filter.sv
// One input channel: two-flop synchroniser, debounce filter and a masked,
// registered rising-edge pulse.
module channel_edge_filter
    import activity_monitor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
)(
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic en,
    output logic event_o
);

    localparam int CNT_W = min1_clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             filt_q;
    logic             filt_d;
    logic             prev_q;
    logic             event_q;
    logic             event_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Debounce next state; any return to the filtered level restarts the count.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            filt_d = sync2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        event_d = filt_q & ~prev_q & en;
    end

    // Synchroniser, filter and edge registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            event_q <= 1'b0;
        end else begin
            sync1_q <= s;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            cnt_q   <= cnt_d;
            event_q <= event_d;
        end
    end

    assign event_o = event_q;

endmodule

// File: rtl/activity_monitor.sv
// Top level: per-channel edge filters, boot pulse, combined activity pulse,
// lowest-index encoder for last_ch and the saturating idle timer.
module activity_monitor
    import activity_monitor_pkg::*;
#(
    parameter  int NUM_CH          = 6,
    parameter  int DEBOUNCE_CYCLES = 4,
    parameter  int IDLE_TIMEOUT    = 1000,
    localparam int CH_W            = min1_clog2(NUM_CH)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] s,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [NUM_CH-1:0] ch_event,
    output logic              R,
    output logic [CH_W-1:0]   last_ch,
    output logic              idle
);

    logic [NUM_CH-1:0] ch_event_s;
    logic              r_s;
    logic              boot_done_q;
    logic              boot_pulse_q;
    logic [CH_W-1:0]   last_ch_q;
    logic [CH_W-1:0]   last_ch_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        channel_edge_filter #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_filter (
            .clk    (clk),
            .rst    (rst),
            .s      (s[i]),
            .en     (ch_mask[i]),
            .event_o(ch_event_s[i])
        );
    end

    // One boot pulse after every reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            boot_done_q  <= 1'b0;
            boot_pulse_q <= 1'b0;
        end else begin
            boot_pulse_q <= ~boot_done_q;
            boot_done_q  <= 1'b1;
        end
    end

    assign r_s = (|ch_event_s) | boot_pulse_q;

    // Descending scan so the lowest active index is the last one written.
    always_comb begin
        last_ch_d = last_ch_q;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            last_ch_d = ch_event_s[i] ? CH_W'(i) : last_ch_d;
        end
    end

    // last_ch register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ch_q <= '0;
        end else begin
            last_ch_q <= last_ch_d;
        end
    end

    if (IDLE_TIMEOUT > 0) begin : g_idle
        localparam int IDLE_W = min1_clog2(IDLE_TIMEOUT + 1);
        localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

        logic [IDLE_W-1:0] idle_cnt_q;
        logic [IDLE_W-1:0] idle_cnt_d;
        logic              idle_q;

        // Saturating idle counter, cleared by any activity.
        always_comb begin
            if (r_s) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q == IDLE_MAX) begin
                idle_cnt_d = idle_cnt_q;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end

        // Idle counter and flag registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                idle_cnt_q <= '0;
                idle_q     <= 1'b0;
            end else begin
                idle_cnt_q <= idle_cnt_d;
                idle_q     <= (idle_cnt_d == IDLE_MAX);
            end
        end

        assign idle = idle_q;
    end else begin : g_no_idle
        assign idle = 1'b0;
    end

    assign ch_event = ch_event_s;
    assign R        = r_s;
    assign last_ch  = last_ch_q;

endmodule

// File: tb/tb_activity_monitor.sv
// Directed bench for activity_monitor (NUM_CH=6, DEBOUNCE_CYCLES=4, IDLE_TIMEOUT=20).
module tb_activity_monitor;

    localparam logic [5:0] M  = 6'b111111;
    localparam logic [5:0] MK = 6'b110111;

    logic       clk;
    logic       rst;
    logic [5:0] s;
    logic [5:0] ch_mask;
    logic [5:0] ch_event;
    logic       R;
    logic [2:0] last_ch;
    logic       idle;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [5:0] s;
        logic [5:0] mask;
        logic [5:0] exp_ev;
        logic       exp_r;
        logic [2:0] exp_last;
        logic       idle_care;
        logic       exp_idle;
    } vec_t;

    vec_t vecs[$];

    activity_monitor #(
        .NUM_CH         (6),
        .DEBOUNCE_CYCLES(4),
        .IDLE_TIMEOUT   (20)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s       (s),
        .ch_mask (ch_mask),
        .ch_event(ch_event),
        .R       (R),
        .last_ch (last_ch),
        .idle    (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] s_v, input logic [5:0] m_v, input logic [5:0] ev_v,
                       input logic r_v, input logic [2:0] last_v, input logic ic, input logic ie);
        vec_t v;
        v.s = s_v; v.mask = m_v; v.exp_ev = ev_v; v.exp_r = r_v;
        v.exp_last = last_v; v.idle_care = ic; v.exp_idle = ie;
        vecs.push_back(v);
    endtask

    task automatic add_run(input int n, input logic [5:0] s_v, input logic [5:0] m_v,
                           input logic [2:0] last_v);
        for (int k = 0; k < n; k++) begin
            add(s_v, m_v, 6'b000000, 1'b0, last_v, 1'b0, 1'b0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        s       = 6'b000000;
        ch_mask = M;

        // Clean press on s[2]; idle drops the cycle after R.
        add(6'b000100, M, 6'b000000, 1'b0, 3'd0, 1'b1, 1'b1);
        add_run(5, 6'b000100, M, 3'd0);
        add(6'b000100, M, 6'b000100, 1'b1, 3'd0, 1'b1, 1'b1);
        add(6'b000100, M, 6'b000000, 1'b0, 3'd2, 1'b1, 1'b0);
        add_run(2, 6'b000100, M, 3'd2);
        add_run(10, 6'b000000, M, 3'd2);
        // Three-cycle glitch on s[0] is rejected.
        add_run(3, 6'b000001, M, 3'd2);
        add_run(10, 6'b000000, M, 3'd2);
        // Four-cycle pulse on s[0] is accepted once.
        add_run(4, 6'b000001, M, 3'd2);
        add_run(2, 6'b000000, M, 3'd2);
        add(6'b000000, M, 6'b000001, 1'b1, 3'd2, 1'b0, 1'b0);
        add_run(9, 6'b000000, M, 3'd0);
        // Simultaneous s[1] and s[4].
        add_run(6, 6'b010010, M, 3'd0);
        add(6'b010010, M, 6'b010010, 1'b1, 3'd0, 1'b0, 1'b0);
        add_run(3, 6'b010010, M, 3'd1);
        add_run(12, 6'b000000, M, 3'd1);
        // Masked press, unmask while held, then a real press.
        add_run(10, 6'b001000, MK, 3'd1);
        add_run(4, 6'b001000, M, 3'd1);
        add_run(10, 6'b000000, M, 3'd1);
        add_run(6, 6'b001000, M, 3'd1);
        add(6'b001000, M, 6'b001000, 1'b1, 3'd1, 1'b0, 1'b0);
        add_run(3, 6'b001000, M, 3'd3);
        add_run(10, 6'b000000, M, 3'd3);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset ch_event", 32'(ch_event), 32'd0);
        check("reset R", 32'(R), 32'd0);
        check("reset last_ch", 32'(last_ch), 32'd0);
        check("reset idle", 32'(idle), 32'd0);

        // Boot pulse and idle timeout.
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                check("boot R", 32'(R), 32'd1);
                check("boot ch_event", 32'(ch_event), 32'd0);
            end
            if (c == 2) check("boot R low", 32'(R), 32'd0);
            if (c == 21) check("idle before timeout", 32'(idle), 32'd0);
            if (c == 22) check("idle at timeout", 32'(idle), 32'd1);
        end

        // Table-driven sequences.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            s       = vecs[i].s;
            ch_mask = vecs[i].mask;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d ch_event", i), 32'(ch_event), 32'(vecs[i].exp_ev));
            check($sformatf("vec%0d R", i), 32'(R), 32'(vecs[i].exp_r));
            check($sformatf("vec%0d last_ch", i), 32'(last_ch), 32'(vecs[i].exp_last));
            if (vecs[i].idle_care) begin
                check($sformatf("vec%0d idle", i), 32'(idle), 32'(vecs[i].exp_idle));
            end
        end

        // Reset two cycles into a debounce on s[5], level held throughout.
        @(negedge clk);
        s       = 6'b100000;
        ch_mask = M;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("midrst%0d ch_event", c), 32'(ch_event), 32'd0);
            check($sformatf("midrst%0d R", c), 32'(R), 32'd0);
            check($sformatf("midrst%0d last_ch", c), 32'(last_ch), 32'd0);
            check($sformatf("midrst%0d idle", c), 32'(idle), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("post%0d ch_event", c), 32'(ch_event), (c == 6) ? 32'h20 : 32'd0);
            check($sformatf("post%0d R", c), 32'(R), (c == 0 || c == 6) ? 32'd1 : 32'd0);
            check($sformatf("post%0d last_ch", c), 32'(last_ch), (c >= 7) ? 32'd5 : 32'd0);
            check($sformatf("post%0d idle", c), 32'(idle), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
